// File: rtl/updown_counter_param.sv
// updown_counter_param
//   Parameterised up/down counter over the range 0..MAX_VAL. It supports
//   synchronous load (clamped to MAX_VAL), an enable prescaler, wrap or
//   saturate behaviour at the range ends, a one-cycle terminal-count pulse
//   and a sticky overflow flag.
//
//   Parameters
//     WIDTH    counter width in bits (>=2)
//     MAX_VAL  top count value (<= 2**WIDTH-1)
//     PRESCALE enabled cycles per count step (>=1)
//
//   Ports
//     clk       rising-edge clock
//     rst_n     synchronous active-low reset
//     en        count enable, advances the prescaler
//     up        1 = increment, 0 = decrement (sampled on the step cycle)
//     load      synchronous load strobe (wins over en)
//     load_val  value to load, clamped to MAX_VAL
//     sat_mode  1 = saturate at the boundary, 0 = wrap
//     clr_ovf   clears the sticky ovf flag (a boundary step in the same cycle wins)
//     cnt       current count, registered
//     tc        terminal-count pulse, registered, one cycle per boundary step
//     ovf       sticky boundary-crossing flag, registered
module updown_counter_param #(
    parameter int WIDTH    = 8,
    parameter int MAX_VAL  = 2**WIDTH - 1,
    parameter int PRESCALE = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic             up,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic             sat_mode,
    input  logic             clr_ovf,
    output logic [WIDTH-1:0] cnt,
    output logic             tc,
    output logic             ovf
);

    localparam logic [WIDTH-1:0] MAX_C = WIDTH'(MAX_VAL);

    logic             step;      // this enabled cycle moves the count
    logic             at_bound;  // the pending step crosses a range end
    logic [WIDTH-1:0] load_clamped;

    assign load_clamped = (load_val > MAX_C) ? MAX_C : load_val;
    assign at_bound     = up ? (cnt == MAX_C) : (cnt == '0);

    generate
        if (PRESCALE > 1) begin : g_ps
            localparam int              PW      = $clog2(PRESCALE);
            localparam logic [PW-1:0]   PS_LAST = PW'(PRESCALE - 1);
            logic [PW-1:0] ps;

            assign step = en && (ps == PS_LAST);

            // Load restarts the prescale period so a loaded value is held for
            // a full PRESCALE enabled cycles before the first step.
            always_ff @(posedge clk) begin
                if (!rst_n) begin
                    ps <= '0;
                end else if (load) begin
                    ps <= '0;
                end else if (en) begin
                    ps <= (ps == PS_LAST) ? '0 : ps + 1'b1;
                end
            end
        end else begin : g_nops
            assign step = en;
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt <= '0;
            tc  <= 1'b0;
            ovf <= 1'b0;
        end else begin
            tc <= 1'b0;
            if (clr_ovf) ovf <= 1'b0;

            if (load) begin
                cnt <= load_clamped;
            end else if (step) begin
                if (at_bound) begin
                    // Boundary step: flag it; in saturate mode cnt simply holds.
                    tc  <= 1'b1;
                    ovf <= 1'b1;   // later assignment wins over clr_ovf
                    if (!sat_mode) cnt <= up ? '0 : MAX_C;
                end else begin
                    cnt <= up ? cnt + 1'b1 : cnt - 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_updown_counter_param.sv
// Testbench for updown_counter_param. Three instances share one set of inputs:
//   k=0: WIDTH=4 MAX_VAL=15 PRESCALE=1
//   k=1: WIDTH=4 MAX_VAL=9  PRESCALE=1
//   k=2: WIDTH=4 MAX_VAL=9  PRESCALE=3
// A behavioural model per instance is checked every cycle, alongside directed
// expectations for the listed scenarios and a randomised phase.
module tb_updown_counter_param;

    localparam int N = 3;

    logic       clk = 1'b0;
    logic       rst_n, en, up, load, sat_mode, clr_ovf;
    logic [3:0] load_val;
    logic [3:0] cnt_o [N];
    logic       tc_o  [N];
    logic       ovf_o [N];

    always #5 clk = ~clk;

    updown_counter_param #(.WIDTH(4), .MAX_VAL(15), .PRESCALE(1)) u0 (
        .clk(clk), .rst_n(rst_n), .en(en), .up(up), .load(load), .load_val(load_val),
        .sat_mode(sat_mode), .clr_ovf(clr_ovf), .cnt(cnt_o[0]), .tc(tc_o[0]), .ovf(ovf_o[0]));
    updown_counter_param #(.WIDTH(4), .MAX_VAL(9), .PRESCALE(1)) u1 (
        .clk(clk), .rst_n(rst_n), .en(en), .up(up), .load(load), .load_val(load_val),
        .sat_mode(sat_mode), .clr_ovf(clr_ovf), .cnt(cnt_o[1]), .tc(tc_o[1]), .ovf(ovf_o[1]));
    updown_counter_param #(.WIDTH(4), .MAX_VAL(9), .PRESCALE(3)) u2 (
        .clk(clk), .rst_n(rst_n), .en(en), .up(up), .load(load), .load_val(load_val),
        .sat_mode(sat_mode), .clr_ovf(clr_ovf), .cnt(cnt_o[2]), .tc(tc_o[2]), .ovf(ovf_o[2]));

    int total = 0;
    int bad   = 0;

    // reference model state
    int mx [N] = '{15, 9, 9};
    int pr [N] = '{1, 1, 3};
    int m_cnt [N];
    int m_ps  [N];
    int m_tc  [N];
    int m_ovf [N];

    task automatic chk(input string tag, input int got, input int exp);
        total++;
        if (got != exp) begin
            bad++;
            $display("FAIL %s got=%0d exp=%0d @%0t", tag, got, exp, $time);
        end
    endtask

    // One rising edge of the model, using the inputs currently driven.
    task automatic model_step();
        for (int k = 0; k < N; k++) begin
            if (!rst_n) begin
                m_cnt[k] = 0; m_ps[k] = 0; m_tc[k] = 0; m_ovf[k] = 0;
            end else begin
                int range = mx[k] + 1;
                int nov   = clr_ovf ? 0 : m_ovf[k];
                int ntc   = 0;
                if (load) begin
                    m_cnt[k] = (int'(load_val) > mx[k]) ? mx[k] : int'(load_val);
                    m_ps[k]  = 0;
                end else if (en) begin
                    m_ps[k] = (m_ps[k] + 1) % pr[k];
                    if (m_ps[k] == 0) begin
                        bit crosses = up ? (m_cnt[k] == mx[k]) : (m_cnt[k] == 0);
                        if (crosses) begin
                            ntc = 1; nov = 1;
                        end
                        if (!(crosses && sat_mode))
                            m_cnt[k] = up ? (m_cnt[k] + 1) % range
                                          : (m_cnt[k] + range - 1) % range;
                    end
                end
                m_tc[k]  = ntc;
                m_ovf[k] = nov;
            end
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
        for (int k = 0; k < N; k++) begin
            chk($sformatf("m_cnt%0d", k), int'(cnt_o[k]), m_cnt[k]);
            chk($sformatf("m_tc%0d",  k), int'(tc_o[k]),  m_tc[k]);
            chk($sformatf("m_ovf%0d", k), int'(ovf_o[k]), m_ovf[k]);
        end
    endtask

    initial begin
        for (int k = 0; k < N; k++) begin
            m_cnt[k] = 0; m_ps[k] = 0; m_tc[k] = 0; m_ovf[k] = 0;
        end
        rst_n = 0; en = 0; up = 1; load = 0; load_val = 0; sat_mode = 0; clr_ovf = 0;
        #2;

        // reset for 2 cycles
        tick(); tick();
        chk("rst_cnt", int'(cnt_o[0]), 0);
        chk("rst_tc",  int'(tc_o[0]),  0);
        chk("rst_ovf", int'(ovf_o[0]), 0);

        // basic up count: mod-16 on u0, mod-10 on u1
        rst_n = 1; en = 1; up = 1; sat_mode = 0;
        for (int i = 1; i <= 20; i++) begin
            tick();
            chk("up16_cnt", int'(cnt_o[0]), i % 16);
            chk("up16_tc",  int'(tc_o[0]),  (i == 16) ? 1 : 0);
            chk("up16_ovf", int'(ovf_o[0]), (i >= 16) ? 1 : 0);
            chk("up10_cnt", int'(cnt_o[1]), i % 10);
            chk("up10_tc",  int'(tc_o[1]),  (i == 10 || i == 20) ? 1 : 0);
        end

        // mid-count reset colliding with load
        repeat (5) tick();
        chk("pre_rst_cnt", int'(cnt_o[1]), 5);
        rst_n = 0; load = 1; load_val = 7;
        tick();
        chk("midrst_cnt", int'(cnt_o[1]), 0);
        chk("midrst_ovf", int'(ovf_o[1]), 0);
        rst_n = 1; load = 0;

        // load 2 with en high, then count down in saturate mode
        load = 1; load_val = 2; en = 1;
        tick();
        chk("ld_cnt", int'(cnt_o[1]), 2);
        chk("ld_tc",  int'(tc_o[1]),  0);
        load = 0; up = 0; sat_mode = 1;
        for (int i = 1; i <= 4; i++) begin
            tick();
            chk("dsat_cnt", int'(cnt_o[1]), (i >= 2) ? 0 : 1);
            chk("dsat_tc",  int'(tc_o[1]),  (i >= 3) ? 1 : 0);
        end
        chk("dsat_ovf", int'(ovf_o[1]), 1);

        // load clamp
        load = 1; load_val = 13; en = 1;
        tick();
        chk("clamp_cnt9",  int'(cnt_o[1]), 9);
        chk("clamp_cnt15", int'(cnt_o[0]), 13);
        load = 0;

        // ovf clear without boundary, then clear colliding with a boundary step
        en = 0; clr_ovf = 1;
        tick();
        chk("clr_ovf", int'(ovf_o[1]), 0);
        en = 1; up = 1; sat_mode = 0; clr_ovf = 1;
        tick();
        chk("coll_cnt", int'(cnt_o[1]), 0);
        chk("coll_tc",  int'(tc_o[1]),  1);
        chk("coll_ovf", int'(ovf_o[1]), 1);
        clr_ovf = 0;

        // prescaler on u2
        rst_n = 0; tick(); rst_n = 1;
        en = 1; up = 1; sat_mode = 0;
        for (int i = 1; i <= 9; i++) begin
            tick();
            chk("ps_cnt", int'(cnt_o[2]), i / 3);
        end
        tick();                      chk("ps_ph0", int'(cnt_o[2]), 3);
        en = 0; tick();              chk("ps_ph1", int'(cnt_o[2]), 3);
        tick();                      chk("ps_ph2", int'(cnt_o[2]), 3);
        en = 1; tick();              chk("ps_ph3", int'(cnt_o[2]), 3);
        tick();                      chk("ps_ph4", int'(cnt_o[2]), 4);

        // randomised phase against the model
        for (int i = 0; i < 400; i++) begin
            rst_n    = ($urandom_range(0, 31) != 0);
            en       = ($urandom_range(0, 3) != 0);
            up       = $urandom_range(0, 1) == 1;
            load     = ($urandom_range(0, 15) == 0);
            load_val = 4'($urandom_range(0, 15));
            sat_mode = ($urandom_range(0, 7) == 0) ? ~sat_mode : sat_mode;
            clr_ovf  = ($urandom_range(0, 7) == 0);
            tick();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
